dcache_ctrl: RTL and testbench

Parametrised direct-mapped data cache for the RISC-V SoC. Sits between the core's load/store port and the unified instruction/data memory. Provides:
- combinational hit lookup with byte-enable writes;
- a multi-beat line-refill FSM over a req/ack memory handshake;
- a write-through, no-write-allocate policy;
- a whole-cache flush walk.

It replaces the fixed single-word cache used by the current minimal SoC.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_data_array.sv | 44 ++++
 rtl/dcache_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the data cache
//
// Purpose: controller state encoding, bus widths and the full-word byte-enable
// constant used by dcache_ctrl and cache_data_array.
// Ports: none (package).
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [BE_W-1:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

endpackage

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - line data storage with byte-enable writes
//
// Purpose: SETS x LINE_WORDS x 32-bit storage. Not reset.
// Ports:
//   clk                  write clock
//   rd_set, rd_word      combinational read address
//   rd_data              read data
//   wr_en                write strobe, applied on the rising edge
//   wr_set, wr_word      write address
//   wr_be, wr_data       per-byte enables and write data
import cache_pkg::*;

module cache_data_array #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  localparam int IW        = $clog2(SETS),
  localparam int WW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic              clk,
  input  logic [IW-1:0]     rd_set,
  input  logic [WW-1:0]     rd_word,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_set,
  input  logic [WW-1:0]     wr_word,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [SETS][LINE_WORDS];

  assign rd_data = mem[rd_set][rd_word];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem[wr_set][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller
//
// Purpose: combinational hit lookup, multi-beat line refill, write-through
// no-write-allocate stores and a whole-cache flush walk.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/we/be/addr/wdata  core load/store request
//   rdata, stall_req            load data, hold-request indication
//   flush                       single-cycle invalidate-all pulse
//   mem_req/we/be/addr/wdata    memory beat request
//   mem_ack, mem_rdata          memory beat completion and read data
import cache_pkg::*;

module dcache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_req,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_W - IDX - OFF;
  localparam int WW  = (LINE_WORDS > 1) ? WB : 1;
  localparam logic [ADDR_W-3:0] WORD_MASK = (ADDR_W-2)'(LINE_WORDS - 1);

  state_t             state;
  logic [WW-1:0]      beat;
  logic [IDX-1:0]     counter;
  logic               flush_pend;
  logic [SETS-1:0]    valid;
  logic [TAG-1:0]     tag_q [SETS];

  logic [TAG-1:0]     tag;
  logic [IDX-1:0]     index;
  logic [WW-1:0]      word;
  logic               hit;
  logic               last_beat;
  logic [DATA_W-1:0]  rd_data;
  logic               dw_en;
  logic               unused_addr_lsbs;

  assign tag   = req_addr[ADDR_W-1:IDX+OFF];
  assign index = req_addr[IDX+OFF-1:OFF];
  // Masking instead of slicing keeps LINE_WORDS = 1 legal (no word field).
  assign word  = WW'(req_addr[ADDR_W-1:2] & WORD_MASK);
  assign unused_addr_lsbs = ^req_addr[1:0];

  assign hit       = valid[index] && (tag_q[index] == tag);
  assign last_beat = (beat == WW'(LINE_WORDS - 1));

  // Refill beats write whole words; store hits merge only the enabled bytes.
  assign dw_en = mem_ack && ((state == ST_REFILL) || (state == ST_WRITE && hit));

  cache_data_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_data (
    .clk     (clk),
    .rd_set  (index),
    .rd_word (word),
    .rd_data (rd_data),
    .wr_en   (dw_en),
    .wr_set  (index),
    .wr_word ((state == ST_REFILL) ? beat : word),
    .wr_be   ((state == ST_REFILL) ? BE_FULL : req_be),
    .wr_data ((state == ST_REFILL) ? mem_rdata : req_wdata)
  );

  always_comb begin
    stall_req = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (flush || flush_pend) begin
          stall_req = req_valid;
        end else if (req_valid) begin
          if (req_we || !hit) stall_req = 1'b1;
          else                rdata     = rd_data;
        end
      end
      ST_REFILL: begin
        stall_req = 1'b1;
        mem_req   = 1'b1;
        mem_be    = BE_FULL;
        mem_addr  = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}} | (ADDR_W'(beat) << 2);
      end
      ST_WRITE: begin
        // Dropping stall on the ack lets the core advance on that same edge.
        stall_req = !mem_ack;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be    = req_be;
        mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = req_wdata;
      end
      ST_FLUSH: begin
        stall_req = req_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      counter    <= '0;
      flush_pend <= 1'b0;
      valid      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush || flush_pend) begin
            state      <= ST_FLUSH;
            counter    <= '0;
            flush_pend <= 1'b0;
          end else if (req_valid) begin
            if (req_we) begin
              state <= ST_WRITE;
            end else if (!hit) begin
              // Invalidate first so an interrupted refill never leaves a stale hit.
              valid[index] <= 1'b0;
              beat         <= '0;
              state        <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[index] <= 1'b1;
              beat         <= '0;
              state        <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_ack) state <= ST_IDLE;
        end
        ST_FLUSH: begin
          valid[counter] <= 1'b0;
          counter        <= counter + 1'b1;
          if (counter == IDX'(SETS - 1)) begin
            counter <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_REFILL && mem_ack && last_beat) begin
      tag_q[index] <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall_req;
  logic        flush = 1'b0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINE_WORDS(4), .SETS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .stall_req (stall_req),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Zero-wait backing memory: untouched words hold a fixed pattern.
  bit   [31:0] wmem   [4096];
  bit          wvalid [4096];
  logic [31:0] rd_addrs [$];
  int          wr_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0]  last_wbe = 4'h0;
  logic [11:0] midx;

  function automatic logic [31:0] pattern(input logic [11:0] i);
    return (i == 12'h041) ? 32'h1122_3344 : {16'hC0DE, 4'h0, i};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign midx      = mem_addr[13:2];
  assign mem_ack   = mem_req;
  assign mem_rdata = wvalid[midx] ? wmem[midx] : pattern(midx);

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        wmem[midx]   <= merge(mem_rdata, mem_wdata, mem_be);
        wvalid[midx] <= 1'b1;
        wr_cnt       <= wr_cnt + 1;
        last_waddr   <= mem_addr;
        last_wdata   <= mem_wdata;
        last_wbe     <= mem_be;
      end else begin
        rd_addrs.push_back(mem_addr);
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One core access; flush is pulsed during stall cycle number flush_at (0 = never).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int flush_at,
                           output int stalls, output logic [31:0] rd);
    int budget;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    stalls = 0; budget = 0;
    @(negedge clk);
    while (stall_req && budget < 500) begin
      stalls++; budget++;
      flush = (stalls == flush_at);
      @(negedge clk);
    end
    flush = 1'b0;
    check_vec("stall_bound", {31'b0, stall_req}, 32'h0);
    rd = rdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  int          st;
  logic [31:0] rd;
  int          r0, w0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("rst_mem_req",   {31'b0, mem_req},   32'h0);
    check_vec("rst_stall",     {31'b0, stall_req}, 32'h0);
    check_vec("rst_rdata",     rdata,              32'h0);
    check_vec("rst_mem_addr",  mem_addr,           32'h0);
    check_vec("rst_mem_be",    {28'b0, mem_be},    32'h0);
    rst = 1'b1;

    // Cold load miss
    r0 = rd_addrs.size();
    do_access(1'b0, 32'h100, 4'h0, 32'h0, 0, st, rd);
    check_vec("cold_stall", st, 5);
    check_vec("cold_rdata", rd, 32'hC0DE_0040);
    check_vec("cold_nreads", rd_addrs.size() - r0, 4);
    for (int k = 0; k < 4; k++)
      if (rd_addrs.size() > r0 + k)
        check_vec("cold_raddr", rd_addrs[r0 + k], 32'h100 + 32'(4 * k));

    // Hit in same line
    r0 = rd_addrs.size();
    do_access(1'b0, 32'h108, 4'h0, 32'h0, 0, st, rd);
    check_vec("hit_stall", st, 0);
    check_vec("hit_rdata", rd, 32'hC0DE_0042);
    check_vec("hit_nreads", rd_addrs.size() - r0, 0);

    // Store hit with one byte lane
    w0 = wr_cnt;
    do_access(1'b1, 32'h104, 4'b0010, 32'hAABB_CCDD, 0, st, rd);
    check_vec("sthit_stall", st, 1);
    check_vec("sthit_nwr", wr_cnt - w0, 1);
    check_vec("sthit_waddr", last_waddr, 32'h104);
    check_vec("sthit_wbe", {28'b0, last_wbe}, 32'h2);
    check_vec("sthit_wdata", last_wdata, 32'hAABB_CCDD);
    r0 = rd_addrs.size();
    do_access(1'b0, 32'h104, 4'h0, 32'h0, 0, st, rd);
    check_vec("sthit_ld_rdata", rd, 32'h1122_CC44);
    check_vec("sthit_ld_stall", st, 0);
    check_vec("sthit_ld_nreads", rd_addrs.size() - r0, 0);

    // Store miss: no allocate
    w0 = wr_cnt; r0 = rd_addrs.size();
    do_access(1'b1, 32'h2000, 4'hF, 32'h1234_5678, 0, st, rd);
    check_vec("stmiss_nwr", wr_cnt - w0, 1);
    check_vec("stmiss_nreads", rd_addrs.size() - r0, 0);
    do_access(1'b0, 32'h2000, 4'h0, 32'h0, 0, st, rd);
    check_vec("stmiss_ld_stall", st, 5);
    check_vec("stmiss_ld_rdata", rd, 32'h1234_5678);

    // Conflict on index 16
    r0 = rd_addrs.size();
    do_access(1'b0, 32'h500, 4'h0, 32'h0, 0, st, rd);
    check_vec("conf_stall", st, 5);
    check_vec("conf_rdata", rd, 32'hC0DE_0140);
    do_access(1'b0, 32'h100, 4'h0, 32'h0, 0, st, rd);
    check_vec("conf_back_stall", st, 5);
    check_vec("conf_back_rdata", rd, 32'hC0DE_0040);
    check_vec("conf_nreads", rd_addrs.size() - r0, 8);

    // Flush pulse during the second refill beat: refill, 64-cycle walk, refill again
    r0 = rd_addrs.size();
    do_access(1'b0, 32'h300, 4'h0, 32'h0, 3, st, rd);
    check_vec("flush_stall", st, 75);
    check_vec("flush_rdata", rd, 32'hC0DE_00C0);
    check_vec("flush_nreads", rd_addrs.size() - r0, 8);
    do_access(1'b0, 32'h100, 4'h0, 32'h0, 0, st, rd);
    check_vec("flush_after_stall", st, 5);

    // Reset after two refill beats
    r0 = rd_addrs.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h700;
    repeat (3) begin @(posedge clk); #1; end
    check_vec("rst_mid_req_pre", {31'b0, mem_req}, 32'h1);
    check_vec("rst_mid_addr_pre", mem_addr, 32'h708);
    check_vec("rst_mid_nreads", rd_addrs.size() - r0, 2);
    rst = 1'b0;
    #1;
    check_vec("rst_mid_req", {31'b0, mem_req}, 32'h0);
    check_vec("rst_mid_addr", mem_addr, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    r0 = rd_addrs.size();
    do_access(1'b0, 32'h700, 4'h0, 32'h0, 0, st, rd);
    check_vec("rst_rf_stall", st, 5);
    check_vec("rst_rf_rdata", rd, 32'hC0DE_01C0);
    check_vec("rst_rf_nreads", rd_addrs.size() - r0, 4);
    if (rd_addrs.size() > r0) check_vec("rst_rf_first", rd_addrs[r0], 32'h700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
